// File: rtl/ppu_pkg.sv
// Shared PPU types and constants for the PPU and its frame-synchronised command queue.
package ppu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    WAIT
  } cmdq_state_t;

  localparam int unsigned VACTIVE_LINES    = 480;
  localparam logic [23:0] BACKGROUND_COLOR = 24'h202020;

endpackage

// File: rtl/ppu_cmd_fifo.sv
// Single-clock show-ahead FIFO with push/pop/flush; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module ppu_cmd_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ppu_cmd_queue.sv
// Avalon-MM command queue that releases buffered PPU words only during vertical blanking.
// Optional status register enabled by defining PPU_CMDQ_STATUS_EN.
module ppu_cmd_queue
  import ppu_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned VACTIVE = VACTIVE_LINES,
  localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic        address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  vcount,
  output logic [31:0] ppu_writedata,
  output logic        ppu_write
);

  localparam logic [9:0] VSTART = 10'(VACTIVE);

  cmdq_state_t   state_q, state_d;
  logic          vblank, push_req, flush_req, pop;
  logic [31:0]   fifo_rdata;
  logic [CW-1:0] count;
  logic          full, empty;

  assign vblank    = (vcount >= VSTART);
  assign push_req  = chipselect & write & ~address;
  assign flush_req = chipselect & write & address;
  // Popping stops as soon as the frame wraps so no word lands mid-frame.
  assign pop       = (state_q == DRAIN) & vblank & ~empty & ~flush_req;

  ppu_cmd_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push_req),
    .pop  (pop),
    .flush(flush_req),
    .wdata(writedata),
    .rdata(fifo_rdata),
    .count(count),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (vblank) state_d = DRAIN;
      DRAIN: begin
        if (flush_req)    state_d = WAIT;
        else if (!vblank) state_d = IDLE;
        else if (empty)   state_d = WAIT;
      end
      WAIT:  if (!vblank) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ppu_writedata <= '0;
      ppu_write     <= 1'b0;
    end else begin
      ppu_write <= pop;
      if (pop) ppu_writedata <= fifo_rdata;
    end
  end

`ifdef PPU_CMDQ_STATUS_EN
  logic       overflow_q;
  logic       status_rd;
  logic [7:0] count8;

  assign status_rd = chipselect & read & ~address;
  assign count8    = 8'(count);

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      readdata   <= '0;
    end else begin
      // A drop in the same cycle as a status read keeps the flag set.
      if (push_req && full && !pop) overflow_q <= 1'b1;
      else if (status_rd)           overflow_q <= 1'b0;
      if (chipselect && read) begin
        readdata <= address ? 32'd0 : {overflow_q, vblank, 22'd0, count8};
      end
    end
  end
`else
  logic unused_status;

  assign readdata      = '0;
  assign unused_status = ^{read, count, full};
`endif

endmodule

// File: tb/tb_ppu_cmd_queue.sv
// Directed self-checking bench for ppu_cmd_queue; status checks adapt to PPU_CMDQ_STATUS_EN.
module tb_ppu_cmd_queue;
  import ppu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic        address = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [9:0]  vcount = '0;
  logic [31:0] ppu_writedata;
  logic        ppu_write;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int base;
  logic [31:0] exp_words [17];

  ppu_cmd_queue #(
    .DEPTH  (16),
    .VACTIVE(480)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .write        (write),
    .read         (read),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .vcount       (vcount),
    .ppu_writedata(ppu_writedata),
    .ppu_write    (ppu_write)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ppu_write === 1'b1) pulses <= pulses + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = 1'b0; writedata = d;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic flush();
    chipselect = 1'b1; write = 1'b1; address = 1'b1;
    step();
    chipselect = 1'b0; write = 1'b0; address = 1'b0;
  endtask

  task automatic rd_status();
    chipselect = 1'b1; read = 1'b1; address = 1'b0;
    step();
    chipselect = 1'b0; read = 1'b0;
  endtask

  initial begin
    // Reset
    step(); step();
    reset = 1'b0;
    vcount = 10'd100;
    check("rst_readdata", readdata, 32'h0);
    check("rst_ppu_writedata", ppu_writedata, 32'h0);
    check("rst_ppu_write", {31'd0, ppu_write}, 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_count", 32'(dut.count), 32'd0);

    // Basic drain in blanking
    push(32'h11); push(32'h22); push(32'h33);
    check("t1_count", 32'(dut.count), 32'd3);
    step();
    check("t1_no_write_active", {31'd0, ppu_write}, 32'h0);
    vcount = 10'd480;
    step();
    check("t1_state_drain", 32'(dut.state_q), 32'(DRAIN));
    check("t1_n1_no_write", {31'd0, ppu_write}, 32'h0);
    step();
    check("t1_w0_strobe", {31'd0, ppu_write}, 32'h1);
    check("t1_w0_data", ppu_writedata, 32'h11);
    step();
    check("t1_w1_data", ppu_writedata, 32'h22);
    step();
    check("t1_w2_data", ppu_writedata, 32'h33);
    check("t1_w2_strobe", {31'd0, ppu_write}, 32'h1);
    step();
    check("t1_done_strobe", {31'd0, ppu_write}, 32'h0);
    check("t1_hold_data", ppu_writedata, 32'h33);
    check("t1_state_wait", 32'(dut.state_q), 32'(WAIT));

    // Overflow: 16 words fill, 17th dropped
    vcount = 10'd100;
    step();
    check("t2_state_idle", 32'(dut.state_q), 32'(IDLE));
    for (int i = 0; i < 16; i++) begin
      exp_words[i] = 32'h200 + 32'(i);
      push(exp_words[i]);
    end
    exp_words[16] = 32'hAA;
    push(32'hDEAD);
    check("t2_count_full", 32'(dut.count), 32'd16);
    rd_status();
`ifdef PPU_CMDQ_STATUS_EN
    check("t2_status1", readdata, 32'h8000_0010);
`else
    check("t2_status1", readdata, 32'h0);
`endif
    rd_status();
`ifdef PPU_CMDQ_STATUS_EN
    check("t2_status2", readdata, 32'h0000_0010);
`else
    check("t2_status2", readdata, 32'h0);
`endif

    // Push while full in the same cycle as a pop
    vcount = 10'd480;
    step();
    check("t4_state_drain", 32'(dut.state_q), 32'(DRAIN));
    chipselect = 1'b1; write = 1'b1; address = 1'b0; writedata = 32'hAA;
    step();
    chipselect = 1'b0; write = 1'b0;
    check("t4_count_stays", 32'(dut.count), 32'd16);
    check("t4_w0_strobe", {31'd0, ppu_write}, 32'h1);
    check("t4_w0_data", ppu_writedata, exp_words[0]);
    for (int i = 1; i < 17; i++) begin
      step();
      check($sformatf("t4_w%0d_strobe", i), {31'd0, ppu_write}, 32'h1);
      check($sformatf("t4_w%0d_data", i), ppu_writedata, exp_words[i]);
    end
    check("t4_count_empty", 32'(dut.count), 32'd0);
    step();
    check("t4_done_strobe", {31'd0, ppu_write}, 32'h0);
    check("t4_state_wait", 32'(dut.state_q), 32'(WAIT));

    // Frame wraps mid-drain
    vcount = 10'd100;
    step();
    for (int i = 0; i < 10; i++) push(32'h100 + 32'(i));
    vcount = 10'd480;
    step();
    step(); step(); step(); step();
    vcount = 10'd0;
    step();
    check("t3_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("t3_count_left", 32'(dut.count), 32'd6);
    check("t3_last_data", ppu_writedata, 32'h103);
    check("t3_strobe_off", {31'd0, ppu_write}, 32'h0);
    base = pulses;
    vcount = 10'd480;
    for (int i = 0; i < 30 && dut.state_q != WAIT; i++) step();
    check("t3_reached_wait", 32'(dut.state_q), 32'(WAIT));
    step();
    check("t3_pulses", 32'(pulses - base), 32'd6);
    check("t3_final_data", ppu_writedata, 32'h109);

    // Flush in IDLE
    vcount = 10'd100;
    step();
    base = pulses;
    for (int i = 0; i < 5; i++) push(32'h400 + 32'(i));
    check("t5_count_pre", 32'(dut.count), 32'd5);
    flush();
    check("t5_count_flushed", 32'(dut.count), 32'd0);
    vcount = 10'd480;
    step(); step(); step(); step();
    check("t5_state_wait", 32'(dut.state_q), 32'(WAIT));
    check("t5_no_pulses", 32'(pulses - base), 32'd0);

    // Reset mid-drain
    vcount = 10'd100;
    step();
    for (int i = 0; i < 8; i++) push(32'h300 + 32'(i));
    vcount = 10'd480;
    step(); step();
    check("t6_pre_strobe", {31'd0, ppu_write}, 32'h1);
    check("t6_pre_data", ppu_writedata, 32'h300);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_data_cleared", ppu_writedata, 32'h0);
    check("t6_strobe_cleared", {31'd0, ppu_write}, 32'h0);
    check("t6_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("t6_count_cleared", 32'(dut.count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
